apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB completer (responder) fronting a word-addressed register/memory array with programmable wait states and error response.
- Sits on the peripheral side of the bridge, opposite the team's APB master.
- Provides the Pready, Prdata and Pslverr signals that the master consumes.
- Used as the default bus target in the bridge verification environment.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_DEPTH.
- WAIT_CYCLES, 2, Pready-low cycles inserted in each ACCESS phase; range 0..15.

Ports:
- Pclk  input  1  clock, rising edge.
- Presetn  input  1  asynchronous active-low reset.
- Psel  input  1  slave select.
- Penable  input  1  access-phase strobe.
- Pwrite  input  1  1=write, 0=read.
- Paddr  input  32  byte address.
- Pdata  input  32  write data.
- Prdata  output  32  read data.
- Pready  output  1  transfer-complete / slave ready.
- Pslverr  output  1  error response, valid when Pready=1 in ACCESS.

Behaviour:
- Reset (async, Presetn=0): state=IDLE, wait counter=0, Prdata=0, Pslverr=0, Pready=1, latched addr/write = 0. Memory contents are not reset.
- FSM, 3 states:
  - IDLE: Psel&!Penable -> SETUP. Psel&Penable (no setup phase) is ignored: stay IDLE, no write.
  - SETUP: latch Paddr, Pwrite; load counter=WAIT_CYCLES; decode error; -> ACCESS unconditionally.
  - ACCESS: if !Psel -> IDLE (aborted, no write). Else if counter!=0 -> decrement, stay. Else (completion) -> SETUP if next cycle shows Psel&!Penable, otherwise -> IDLE.
- Pready is combinational: 1 in IDLE and SETUP; in ACCESS, 1 only when counter==0. This keeps a master that waits on Pready in its setup phase unblocked.
- Latency: WAIT_CYCLES=0 gives a 2-cycle transfer (SETUP, ACCESS). Each wait cycle adds 1.
- Error decode (in SETUP, registered):
  - err = Paddr[1:0]!=0, or Paddr<BASE_ADDR, or Paddr>=BASE_ADDR+4*MEM_DEPTH.
  - Pslverr = err during the ACCESS completion cycle only; 0 otherwise.
- Index = (Paddr-BASE_ADDR)[log2(MEM_DEPTH)+1:2].
- Write: commit Pdata to mem[index] on the completion edge (ACCESS, Pready=1, Psel=1) only if !err. Pdata is sampled at that edge, not at setup.
- Read: synchronous array read issued in SETUP; Prdata is valid from the first ACCESS cycle and held until the next read completes.
  - Error reads drive Prdata=0.
  - Writes do not alter Prdata.
- Paddr/Pwrite changes during ACCESS are ignored (latched values used).
- Reset mid-transfer: immediate IDLE, pending write dropped, outputs to reset values.

Optional Feature:
- Macro: APB_SLV_PSTRB_EN.
- Defined: adds input Pstrb[3:0]. On write, byte lane i is updated only if Pstrb[i]=1. Pstrb=0 with no error is a legal no-op write. Reads ignore Pstrb.
- Undefined: port absent; all writes are full 32-bit words.

Decomposition:
- Shared package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - APB_DATA_W=32 and APB_ADDR_W=32;
  - WAIT_CNT_W=4;
  - the error-decode helper function.
- One sub-module, apb_slave_mem_array: single-port synchronous RAM with read enable, write enable and optional 4-bit byte-enable (tied 4'hF when the macro is off).

Test Plan:
- Write 0xDEAD_BEEF to 0x10, then read 0x10 (WAIT_CYCLES=2) -> each ACCESS shows Pready low 2 cycles then high 1. Read Prdata=0xDEAD_BEEF, Pslverr=0.
- WAIT_CYCLES=0, back-to-back writes to 0x0 and 0x4 with no IDLE between -> each completes in 2 cycles. Reads then return the written values.
- Read 0x402 (misaligned), and write 0x400 with MEM_DEPTH=256 -> Pslverr=1 on completion, Prdata=0, no memory location modified.
- Psel dropped during ACCESS wait of a write to 0x8 -> FSM returns to IDLE, and a later read of 0x8 returns the prior value.
- Presetn pulsed low mid-ACCESS -> Pready=1, Pslverr=0, Prdata=0 immediately. The next transfer completes normally.
- With APB_SLV_PSTRB_EN: write 0x1122_3344 to 0x20, then write 0xAABB_CCDD with Pstrb=4'b0101 -> read 0x20 returns 0x11BB_33DD.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB completer memory: bus widths, the wait
// counter width, the transfer phase enum and the address-error decoder.
// Optional feature macro used by the files importing this package:
//   APB_SLV_PSTRB_EN - adds a 4-bit Pstrb byte-lane write mask.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // An address is rejected when it is not word aligned or falls outside
  // [base, base+span). The upper bound is evaluated one bit wider so a
  // window ending exactly at 4 GiB does not wrap.
  function automatic logic addr_err(input logic [APB_ADDR_W-1:0] addr,
                                    input logic [APB_ADDR_W-1:0] base,
                                    input logic [APB_ADDR_W:0]   span);
    logic [APB_ADDR_W:0] addr_ext;
    logic [APB_ADDR_W:0] limit;
    addr_ext = {1'b0, addr};
    limit    = {1'b0, base} + span;
    return (addr[1:0] != 2'b00) || (addr < base) || (addr_ext >= limit);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_if
// APB bus bundle between a requester (master modport) and the memory
// completer (slave modport).
//   Psel, Penable, Pwrite, Paddr, Pdata : requester -> completer
//   Pstrb (only with APB_SLV_PSTRB_EN)  : requester -> completer
//   Prdata, Pready, Pslverr             : completer -> requester
// ---------------------------------------------------------------------------
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic                  Psel;
  logic                  Penable;
  logic                  Pwrite;
  logic [APB_ADDR_W-1:0] Paddr;
  logic [APB_DATA_W-1:0] Pdata;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]            Pstrb;
`endif
  logic [APB_DATA_W-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;

`ifdef APB_SLV_PSTRB_EN
  modport master (output Psel, Penable, Pwrite, Paddr, Pdata, Pstrb,
                  input  Prdata, Pready, Pslverr);
  modport slave  (input  Psel, Penable, Pwrite, Paddr, Pdata, Pstrb,
                  output Prdata, Pready, Pslverr);
`else
  modport master (output Psel, Penable, Pwrite, Paddr, Pdata,
                  input  Prdata, Pready, Pslverr);
  modport slave  (input  Psel, Penable, Pwrite, Paddr, Pdata,
                  output Prdata, Pready, Pslverr);
`endif

endinterface

// File: rtl/apb_slave_mem_array.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_array
// Single-port synchronous RAM with byte-lane write enables and a registered
// read port. Storage is not reset; only the read register is.
//   clk_i, rst_n_i : clock, async active-low reset (read register only)
//   re_i           : load rdata_o from mem[idx_i] on the next edge
//   we_i, be_i     : write enable and per-byte lane mask
//   idx_i, wdata_i : word index and write data
//   rdata_o        : registered read data
// ---------------------------------------------------------------------------
module apb_slave_mem_array
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] rdata_q;

  // Byte-lane masked write into the storage array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= {APB_DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// APB completer in front of a MEM_DEPTH x 32-bit word memory, with
// WAIT_CYCLES Pready-low cycles per access and Pslverr for misaligned or
// out-of-window addresses.
//   Pclk, Presetn : clock (rising edge), async active-low reset
//   bus (slave)   : Psel/Penable/Pwrite/Paddr/Pdata[/Pstrb] in,
//                   Prdata/Pready/Pslverr out
// Optional macro APB_SLV_PSTRB_EN enables Pstrb byte-lane writes; without
// it every write updates the full word.
// ---------------------------------------------------------------------------
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned          MEM_DEPTH   = 256,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned          WAIT_CYCLES = 2
) (
  input  logic           Pclk,
  input  logic           Presetn,
  apb_slave_mem_if.slave bus
);

  localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [APB_ADDR_W:0]   SPAN      = (APB_ADDR_W+1)'(4 * MEM_DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  apb_state_e            state_q;
  apb_state_e            phase_s;
  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic                  rd_err_q;

  logic                  cnt_zero_s;
  logic                  req_err_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic [IDX_W-1:0]      mem_idx_s;
  logic                  rd_en_s;
  logic                  wr_en_s;
  logic [3:0]            be_s;
  logic [APB_DATA_W-1:0] rdata_s;

  // The register only ever rests in IDLE or ACCESS: the SETUP phase is the
  // cycle in which the bus shows Psel&!Penable while idle, so latching and
  // the array read happen on that cycle's edge and ACCESS lines up with the
  // requester's access phase. A completion returning to IDLE therefore
  // flows straight into SETUP when the next setup phase follows at once.
  always_comb begin
    phase_s = state_q;
    if ((state_q == IDLE) && bus.Psel && !bus.Penable) begin
      phase_s = SETUP;
    end else begin
      phase_s = state_q;
    end
  end

  assign cnt_zero_s = (cnt_q == {WAIT_CNT_W{1'b0}});
  assign req_err_s  = addr_err(bus.Paddr, BASE_ADDR, SPAN);
  assign req_idx_s  = IDX_W'((bus.Paddr - BASE_ADDR) >> 2);
  assign mem_idx_s  = (phase_s == SETUP) ? req_idx_s : idx_q;
  assign rd_en_s    = (phase_s == SETUP) && !bus.Pwrite;
  // Pdata is taken at the completion edge, not at setup.
  assign wr_en_s    = (state_q == ACCESS) && cnt_zero_s && bus.Psel &&
                      write_q && !err_q;

`ifdef APB_SLV_PSTRB_EN
  assign be_s = bus.Pstrb;
`else
  assign be_s = 4'hF;
`endif

  // Transfer FSM: latch request in SETUP, count wait states in ACCESS.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state_q  <= IDLE;
      cnt_q    <= {WAIT_CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      case (phase_s)
        SETUP: begin
          idx_q   <= req_idx_s;
          write_q <= bus.Pwrite;
          cnt_q   <= WAIT_LOAD;
          err_q   <= req_err_s;
          // Only reads own the Prdata zero-forcing flag; writes leave it.
          if (!bus.Pwrite) begin
            rd_err_q <= req_err_s;
          end
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (!bus.Psel) begin
            state_q <= IDLE;
          end else if (!cnt_zero_s) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  apb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (Pclk),
    .rst_n_i (Presetn),
    .re_i    (rd_en_s),
    .we_i    (wr_en_s),
    .be_i    (be_s),
    .idx_i   (mem_idx_s),
    .wdata_i (bus.Pdata),
    .rdata_o (rdata_s)
  );

  // Pready stays high outside ACCESS so a requester polling it during its
  // setup phase is never held off.
  assign bus.Pready  = (state_q != ACCESS) || cnt_zero_s;
  assign bus.Pslverr = (state_q == ACCESS) && cnt_zero_s && err_q;
  assign bus.Prdata  = rd_err_q ? {APB_DATA_W{1'b0}} : rdata_s;

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;
  import apb_pkg::*;

  logic Pclk    = 1'b0;
  logic Presetn = 1'b0;
  always #5 Pclk = ~Pclk;

  // Unit 0: WAIT_CYCLES=2, unit 1: WAIT_CYCLES=0.
  apb_slave_mem_if bus2 ();
  apb_slave_mem_if bus0 ();

  apb_slave_mem #(.MEM_DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2))
    dut2 (.Pclk(Pclk), .Presetn(Presetn), .bus(bus2.slave));
  apb_slave_mem #(.MEM_DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0))
    dut0 (.Pclk(Pclk), .Presetn(Presetn), .bus(bus0.slave));

  logic        psel_a    [2];
  logic        penable_a [2];
  logic        pwrite_a  [2];
  logic [31:0] paddr_a   [2];
  logic [31:0] pdata_a   [2];
  logic [3:0]  pstrb_a   [2];
  logic        in_xfer_a [2];
  logic        pready_a  [2];
  logic        pslverr_a [2];
  logic [31:0] prdata_a  [2];

  assign bus2.Psel = psel_a[0];    assign bus0.Psel = psel_a[1];
  assign bus2.Penable = penable_a[0]; assign bus0.Penable = penable_a[1];
  assign bus2.Pwrite = pwrite_a[0];  assign bus0.Pwrite = pwrite_a[1];
  assign bus2.Paddr = paddr_a[0];   assign bus0.Paddr = paddr_a[1];
  assign bus2.Pdata = pdata_a[0];   assign bus0.Pdata = pdata_a[1];
`ifdef APB_SLV_PSTRB_EN
  assign bus2.Pstrb = pstrb_a[0];   assign bus0.Pstrb = pstrb_a[1];
`endif
  assign pready_a[0] = bus2.Pready;   assign pready_a[1] = bus0.Pready;
  assign pslverr_a[0] = bus2.Pslverr; assign pslverr_a[1] = bus0.Pslverr;
  assign prdata_a[0] = bus2.Prdata;   assign prdata_a[1] = bus0.Prdata;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One complete transfer; the expected completion response goes to the
  // scoreboard and the monitor checks it when Pready completes the access.
  task automatic xfer(input int u, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input string name, input logic chk_data,
                      input logic [31:0] rdata, input logic err, input int waits_exp);
    exp_t e;
    int   waits;
    e.name = name; e.chk_data = chk_data; e.rdata = rdata; e.err = err;
    if (u == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    psel_a[u] = 1'b1; penable_a[u] = 1'b0; pwrite_a[u] = wr;
    paddr_a[u] = addr; pdata_a[u] = data; pstrb_a[u] = strb;
    in_xfer_a[u] = 1'b1;
    @(posedge Pclk); #1;
    penable_a[u] = 1'b1;
    waits = 0;
    while (!pready_a[u] && waits < 40) begin
      @(posedge Pclk); #1;
      waits++;
    end
    cmp32({name, " wait cycles"}, waits, waits_exp);
    @(posedge Pclk); #1;
    psel_a[u] = 1'b0; penable_a[u] = 1'b0; in_xfer_a[u] = 1'b0;
  endtask

  // Monitor: pop and compare on every completed access cycle.
  always @(negedge Pclk) begin
    for (int u = 0; u < 2; u++) begin
      if (in_xfer_a[u] && psel_a[u] && penable_a[u] && pready_a[u]) begin
        exp_t e;
        logic have;
        have = 1'b0;
        if (u == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        else if (u == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        if (!have) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected completion on unit %0d", u);
        end else begin
          cmp32({e.name, " Pslverr"}, {31'd0, pslverr_a[u]}, {31'd0, e.err});
          if (e.chk_data) cmp32({e.name, " Prdata"}, prdata_a[u], e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      psel_a[u] = 1'b0; penable_a[u] = 1'b0; pwrite_a[u] = 1'b0;
      paddr_a[u] = 32'd0; pdata_a[u] = 32'd0; pstrb_a[u] = 4'hF; in_xfer_a[u] = 1'b0;
    end
    Presetn = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      cmp32("reset Pready", {31'd0, pready_a[u]}, 32'd1);
      cmp32("reset Pslverr", {31'd0, pslverr_a[u]}, 32'd0);
      cmp32("reset Prdata", prdata_a[u], 32'd0);
    end
    Presetn = 1'b1;
    @(posedge Pclk); #1;

    // Basic write/read with two wait states.
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr 0x10", 1'b0, 32'd0, 1'b0, 2);
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF, "rd 0x10", 1'b1, 32'hDEAD_BEEF, 1'b0, 2);

    // Zero wait states, back-to-back with no idle cycle between.
    xfer(1, 1'b1, 32'h0, 32'h1111_1111, 4'hF, "w0 wr 0x0", 1'b0, 32'd0, 1'b0, 0);
    xfer(1, 1'b1, 32'h4, 32'h2222_2222, 4'hF, "w0 wr 0x4", 1'b0, 32'd0, 1'b0, 0);
    xfer(1, 1'b0, 32'h0, 32'd0, 4'hF, "w0 rd 0x0", 1'b1, 32'h1111_1111, 1'b0, 0);
    xfer(1, 1'b0, 32'h4, 32'd0, 4'hF, "w0 rd 0x4", 1'b1, 32'h2222_2222, 1'b0, 0);

    // Access phase without a setup phase must not write.
    psel_a[1] = 1'b1; penable_a[1] = 1'b1; pwrite_a[1] = 1'b1;
    paddr_a[1] = 32'h4; pdata_a[1] = 32'hFFFF_FFFF;
    repeat (3) @(posedge Pclk);
    #1;
    psel_a[1] = 1'b0; penable_a[1] = 1'b0;
    xfer(1, 1'b0, 32'h4, 32'd0, 4'hF, "no-setup ignored", 1'b1, 32'h2222_2222, 1'b0, 0);

    // Error responses; the out-of-window write would alias word 0.
    xfer(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, "wr 0x0", 1'b0, 32'd0, 1'b0, 2);
    xfer(0, 1'b0, 32'h402, 32'd0, 4'hF, "rd misaligned", 1'b1, 32'd0, 1'b1, 2);
    xfer(0, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, "wr out-of-range", 1'b1, 32'd0, 1'b1, 2);
    xfer(0, 1'b0, 32'h0, 32'd0, 4'hF, "rd 0x0 untouched", 1'b1, 32'hA5A5_A5A5, 1'b0, 2);
    xfer(0, 1'b0, 32'h400, 32'd0, 4'hF, "rd out-of-range", 1'b1, 32'd0, 1'b1, 2);

    // Write aborted by dropping Psel during a wait state.
    xfer(0, 1'b1, 32'h8, 32'h1234_5678, 4'hF, "wr 0x8", 1'b0, 32'd0, 1'b0, 2);
    psel_a[0] = 1'b1; penable_a[0] = 1'b0; pwrite_a[0] = 1'b1;
    paddr_a[0] = 32'h8; pdata_a[0] = 32'hFFFF_0000;
    @(posedge Pclk); #1;
    penable_a[0] = 1'b1;
    cmp32("abort wait Pready", {31'd0, pready_a[0]}, 32'd0);
    @(posedge Pclk); #1;
    psel_a[0] = 1'b0; penable_a[0] = 1'b0;
    @(posedge Pclk); #1;
    cmp32("abort idle Pready", {31'd0, pready_a[0]}, 32'd1);
    xfer(0, 1'b0, 32'h8, 32'd0, 4'hF, "rd 0x8 after abort", 1'b1, 32'h1234_5678, 1'b0, 2);

    // Reset pulsed during an access wait state.
    psel_a[0] = 1'b1; penable_a[0] = 1'b0; pwrite_a[0] = 1'b0; paddr_a[0] = 32'h10;
    @(posedge Pclk); #1;
    penable_a[0] = 1'b1;
    cmp32("pre-reset Prdata", prdata_a[0], 32'hDEAD_BEEF);
    cmp32("pre-reset Pready", {31'd0, pready_a[0]}, 32'd0);
    Presetn = 1'b0;
    #1;
    cmp32("mid-reset Pready", {31'd0, pready_a[0]}, 32'd1);
    cmp32("mid-reset Pslverr", {31'd0, pslverr_a[0]}, 32'd0);
    cmp32("mid-reset Prdata", prdata_a[0], 32'd0);
    psel_a[0] = 1'b0; penable_a[0] = 1'b0;
    #2;
    Presetn = 1'b1;
    @(posedge Pclk); #1;
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF, "rd after reset", 1'b1, 32'hDEAD_BEEF, 1'b0, 2);

`ifdef APB_SLV_PSTRB_EN
    xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, "strb wr full", 1'b0, 32'd0, 1'b0, 2);
    xfer(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, "strb wr 0101", 1'b0, 32'd0, 1'b0, 2);
    xfer(0, 1'b1, 32'h20, 32'h0000_0000, 4'b0000, "strb wr none", 1'b0, 32'd0, 1'b0, 2);
    xfer(0, 1'b0, 32'h20, 32'd0, 4'b0000, "strb rd 0x20", 1'b1, 32'h11BB_33DD, 1'b0, 2);
`endif

    repeat (3) @(posedge Pclk);
    #1;
    cmp32("scoreboard drained", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
